// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
package arb_pkg;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int N_DEF = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_w(N_DEF);

endpackage

// File: rtl/arbiter_chain.sv
// Ripple priority chain: lowest set request bit wins while the carry is high.
module arbiter_chain #(
   parameter int N = 4
) (
   input  logic [N-1:0] r,
   input  logic         cin,
   output logic [N-1:0] g,
   output logic         cout
);

   logic carry;

   // carry models the cell-to-cell ripple; it drops at the first request seen
   always_comb begin
      carry = cin;
      g     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         g[i]  = r[i] & carry;
         carry = carry & ~r[i];
      end
   end

   assign cout = carry;

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant hold and back-to-back handover.
// Optional forced-release timer enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int MAX_HOLD = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        r,
   input  logic                done,
   output logic [N-1:0]        g,
   output logic                gnt_valid,
   output logic [idx_w(N)-1:0] gnt_id,
   output logic                timeout
);

   localparam int IW = idx_w(N);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("rr_arbiter: N must be in 2..16");
   end
   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("rr_arbiter: MAX_HOLD must be at least 1");
   end

   state_t          state, state_nx;
   logic [IW-1:0]   ptr, ptr_nx, ptr_inc, sel_ptr, id_nx, win_id;
   logic [N-1:0]    g_nx, rot_r, rot_g, win;
   logic [2*N-1:0]  dbl_r, dbl_g;
   logic            cout, nat_rel, expiry, forced, rel, to_nx;

   assign ptr_inc = (gnt_id == IW'(N-1)) ? '0 : gnt_id + 1'b1;
   assign nat_rel = done | ~r[gnt_id];
   assign forced  = (state == GRANT) & expiry & ~nat_rel;
   assign rel     = (state == GRANT) & (nat_rel | expiry);

   // While releasing, arbitrate with the already-advanced pointer so the
   // handover happens in the same edge without an idle bubble.
   assign sel_ptr = (state == GRANT) ? ptr_inc : ptr;
   assign dbl_r   = {r, r} >> sel_ptr;
   assign rot_r   = dbl_r[N-1:0];
   assign dbl_g   = {rot_g, rot_g} << sel_ptr;
   assign win     = dbl_g[2*N-1:N];

   arbiter_chain #(.N(N)) u_chain (
      .r    (rot_r),
      .cin  (1'b1),
      .g    (rot_g),
      .cout (cout)
   );

   always_comb begin
      win_id = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win[i]) win_id = IW'(i);
      end
   end

   always_comb begin
      state_nx = state;
      g_nx     = g;
      id_nx    = gnt_id;
      ptr_nx   = ptr;
      to_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (!cout) begin
               state_nx = GRANT;
               g_nx     = win;
               id_nx    = win_id;
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_nx = ptr_inc;
               to_nx  = forced;
               if (!cout) begin
                  g_nx  = win;
                  id_nx = win_id;
               end else begin
                  state_nx = IDLE;
                  g_nx     = '0;
                  id_nx    = '0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         g       <= '0;
         gnt_id  <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         g       <= g_nx;
         gnt_id  <= id_nx;
         timeout <= to_nx;
      end
   end

   assign gnt_valid = |g;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (state == GRANT && !rel) begin
         hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

   assign expiry = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));
`else
   assign expiry = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: behavioural model plus directed and random stimulus.
module tb_rr_arbiter;
   import arb_pkg::*;

   localparam int N = 4;
`ifdef RR_ARB_TIMEOUT_EN
   localparam int TB_MAX_HOLD = 4;
   localparam bit TO_EN       = 1'b1;
`else
   localparam int TB_MAX_HOLD = 16;
   localparam bit TO_EN       = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     r = '0;
   logic             done = 1'b0;
   logic [N-1:0]     g;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_id;
   logic             timeout;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arbiter #(.N(N), .MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .r         (r),
      .done      (done),
      .g         (g),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: owner index (-1 idle), priority pointer, hold length, pending pulse.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_to    = 1'b0;
   bit m_live  = 1'b0;

   function automatic int pick(input logic [N-1:0] req, input int p);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (p + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0; m_live = 1'b1;
      end else if (m_live) begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_hold  = 0;
         end else begin
            bit nat, frc;
            nat = done || !r[m_owner];
            frc = TO_EN && (m_hold == TB_MAX_HOLD - 1) && !nat;
            if (nat || frc) begin
               m_ptr   = (m_owner + 1) % N;
               m_to    = frc;
               m_owner = pick(r, m_ptr);
               m_hold  = 0;
            end else begin
               m_hold++;
            end
         end
      end
      if (m_live) begin
         #1;
         check("model_g", 32'(g), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
         check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         check("model_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
         check("model_timeout", 32'(timeout), 32'(m_to));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int exp_order [5] = '{0, 1, 2, 3, 0};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_g", 32'(g), 32'd0);
         check("idle_id", 32'(gnt_id), 32'd0);
      end

      // First grant from ptr=0, then back-to-back handover on done
      @(negedge clk); r = 4'b1010;
      tick();
      check("first_g", 32'(g), 32'b0010);
      check("first_id", 32'(gnt_id), 32'd1);
      @(negedge clk); done = 1'b1;
      tick();
      check("b2b_g", 32'(g), 32'b1000);
      check("b2b_id", 32'(gnt_id), 32'd3);
      @(negedge clk); done = 1'b0; r = '0;
      tick();
      check("drop_idle_g", 32'(g), 32'd0);

      // Wrap-around with all requesting
      @(negedge clk); r = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("wrap_order", 32'(gnt_id), 32'(exp_order[k]));
         @(negedge clk);
         @(negedge clk); done = 1'b1;
         @(negedge clk); done = 1'b0;
      end
      r = '0;

      // Withdrawal and reset mid-grant
      @(negedge clk); reset = 1'b1;
      tick();
      @(negedge clk); reset = 1'b0; r = 4'b0100;
      tick();
      check("wd_own2", 32'(g), 32'b0100);
      @(negedge clk); r = 4'b0001;
      tick();
      check("wd_g", 32'(g), 32'b0001);
      @(negedge clk); r = 4'b0100;
      tick();
      check("pre_rst_g", 32'(g), 32'b0100);
      @(negedge clk); reset = 1'b1;
      tick();
      check("rst_mid_g", 32'(g), 32'd0);
      check("rst_mid_to", 32'(timeout), 32'd0);
      @(negedge clk); reset = 1'b0; r = 4'b0100;
      tick();
      check("rereq_id", 32'(gnt_id), 32'd2);
      @(negedge clk); r = '0;
      tick();

`ifdef RR_ARB_TIMEOUT_EN
      @(negedge clk); reset = 1'b1;
      tick();
      @(negedge clk); reset = 1'b0; r = 4'b0011;
      tick();
      check("to_hold0", 32'(g), 32'b0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_hold_g", 32'(g), 32'b0001);
         check("to_hold_pulse", 32'(timeout), 32'd0);
      end
      tick();
      check("to_force_g", 32'(g), 32'b0010);
      check("to_force_pulse", 32'(timeout), 32'd1);
      tick();
      check("to_pulse_end", 32'(timeout), 32'd0);
      tick();
      tick();
      @(negedge clk); done = 1'b1;
      tick();
      check("to_done_g", 32'(g), 32'b0001);
      check("to_done_pulse", 32'(timeout), 32'd0);
      @(negedge clk); done = 1'b0; r = '0;
      tick();
`endif

      // Random traffic checked against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) != 0) r = N'($urandom_range(0, 15));
         done = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk); reset = 1'b0; r = '0; done = 1'b0;
      repeat (3) @(posedge clk);
      #3;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
